id_ex_dump_tx: RTL and testbench

- Read-side companion of the ID/EX pipeline latch for the debug unit.
- On a dump request, snapshots the latch outputs (PC+8, RS data, RT data, sign extension, control word) in one cycle.
- Serialises the snapshot as a framed byte stream over a valid/ready byte interface toward the debug UART transmitter.
- Lets the debug host inspect ID/EX state while the pipeline is stepped or halted.

---
 rtl/debug_pkg.sv | 16 +
 rtl/dump_byte_mux.sv | 22 ++
 rtl/id_ex_dump_tx.sv | 131 +++++++++++++
 tb/tb_id_ex_dump_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: frame header, FSM state codes and frame length.
package debug_pkg;

    localparam logic [7:0] HEADER = 8'hA5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int unsigned frame_len(input int unsigned nb_reg,
                                              input int unsigned nb_ctrl,
                                              input bit          with_csum);
        return 1 + 4 * (nb_reg / 8) + nb_ctrl / 8 + (with_csum ? 1 : 0);
    endfunction

endpackage

// File: rtl/dump_byte_mux.sv
// Combinational byte selector: byte 0 is the most significant byte of i_vec.
module dump_byte_mux #(
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned N_BYTES = 19,
    parameter int unsigned IDX_W   = 5
) (
    input  logic [NB_BYTE*N_BYTES-1:0] i_vec,
    input  logic [IDX_W-1:0]           i_idx,
    output logic [NB_BYTE-1:0]         o_byte
);

    // Indices past the vector (e.g. a trailing checksum slot) yield zero.
    always_comb begin
        o_byte = '0;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_byte = i_vec[NB_BYTE*(N_BYTES-1-i) +: NB_BYTE];
            end
        end
    end

endmodule

// File: rtl/id_ex_dump_tx.sv
// Snapshots the ID/EX latch on request and streams it as a framed byte sequence.
// Optional trailing XOR checksum byte when ID_EX_DUMP_CHECKSUM_EN is defined.
module id_ex_dump_tx #(
    parameter int unsigned          NB_REG  = 32,
    parameter int unsigned          NB_CTRL = 16,
    parameter int unsigned          NB_BYTE = 8,
    parameter logic [NB_BYTE-1:0]   HEADER  = debug_pkg::HEADER
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_req,
    input  logic [NB_REG-1:0]  i_pc_eight,
    input  logic [NB_REG-1:0]  i_rs_data,
    input  logic [NB_REG-1:0]  i_rt_data,
    input  logic [NB_REG-1:0]  i_sign_extension,
    input  logic [NB_CTRL-1:0] i_control_unit,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    import debug_pkg::*;

`ifdef ID_EX_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    localparam int unsigned N      = frame_len(NB_REG, NB_CTRL, CSUM);
    localparam int unsigned N_DATA = frame_len(NB_REG, NB_CTRL, 1'b0);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned VEC_W  = NB_BYTE + 4 * NB_REG + NB_CTRL;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [NB_REG-1:0]  r_pc;
    logic [NB_REG-1:0]  r_rs;
    logic [NB_REG-1:0]  r_rt;
    logic [NB_REG-1:0]  r_sext;
    logic [NB_CTRL-1:0] r_ctrl;

    logic [VEC_W-1:0]   w_vec;
    logic [NB_BYTE-1:0] w_byte;
    logic               w_fire;
    logic               w_start;

    assign w_vec   = {HEADER, r_pc, r_rs, r_rt, r_sext, r_ctrl};
    assign w_fire  = (r_state == SEND) && i_tx_ready;
    assign w_start = (r_state == IDLE) && i_dump_req;

    dump_byte_mux #(
        .NB_BYTE (NB_BYTE),
        .N_BYTES (N_DATA),
        .IDX_W   (IDX_W)
    ) u_mux (
        .i_vec  (w_vec),
        .i_idx  (r_idx),
        .o_byte (w_byte)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pc    <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_sext  <= '0;
            r_ctrl  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_dump_req) begin
                        r_pc    <= i_pc_eight;
                        r_rs    <= i_rs_data;
                        r_rt    <= i_rt_data;
                        r_sext  <= i_sign_extension;
                        r_ctrl  <= i_control_unit;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_fire) begin
                        if (r_idx == LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ID_EX_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_csum;

    // Accumulates every accepted byte except the checksum slot itself.
    always_ff @(posedge i_clk) begin
        if (!i_reset || w_start) begin
            r_csum <= '0;
        end else if (w_fire && (r_idx != LAST)) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    always_comb begin
        o_tx_data = '0;
        if (r_state == SEND) begin
            o_tx_data = w_byte;
`ifdef ID_EX_DUMP_CHECKSUM_EN
            if (r_idx == LAST) begin
                o_tx_data = r_csum;
            end
`endif
        end
    end

    assign o_tx_valid = (r_state == SEND);
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);

endmodule

// File: tb/tb_id_ex_dump_tx.sv
// Self-checking bench for id_ex_dump_tx: directed and randomized frames vs. a byte-queue model.
module tb_id_ex_dump_tx;

    localparam int NB_REG  = 32;
    localparam int NB_CTRL = 16;
    localparam int NB_BYTE = 8;
`ifdef ID_EX_DUMP_CHECKSUM_EN
    localparam int N = 20;
`else
    localparam int N = 19;
`endif

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_dump_req = 1'b0;
    logic [NB_REG-1:0]  i_pc_eight = '0;
    logic [NB_REG-1:0]  i_rs_data = '0;
    logic [NB_REG-1:0]  i_rt_data = '0;
    logic [NB_REG-1:0]  i_sign_extension = '0;
    logic [NB_CTRL-1:0] i_control_unit = '0;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready = 1'b0;
    logic               o_busy;
    logic               o_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    id_ex_dump_tx #(
        .NB_REG  (NB_REG),
        .NB_CTRL (NB_CTRL),
        .NB_BYTE (NB_BYTE),
        .HEADER  (8'hA5)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_dump_req       (i_dump_req),
        .i_pc_eight       (i_pc_eight),
        .i_rs_data        (i_rs_data),
        .i_rt_data        (i_rt_data),
        .i_sign_extension (i_sign_extension),
        .i_control_unit   (i_control_unit),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .i_tx_ready       (i_tx_ready),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, each word MSB byte first, optional XOR of everything before.
    task automatic build_frame(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] se, input logic [15:0] ctrl);
        logic [31:0] words [4];
        logic [7:0]  x;
        words = '{pc, rs, rt, se};
        exp_q.delete();
        exp_q.push_back(8'hA5);
        foreach (words[w])
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
        exp_q.push_back(ctrl[15:8]);
        exp_q.push_back(ctrl[7:0]);
`ifdef ID_EX_DUMP_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic set_inputs(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] se, input logic [15:0] ctrl);
        i_pc_eight = pc; i_rs_data = rs; i_rt_data = rt; i_sign_extension = se; i_control_unit = ctrl;
    endtask

    // Called at a negedge; the request is sampled on the following posedge.
    task automatic do_req(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] se, input logic [15:0] ctrl);
        set_inputs(pc, rs, rt, se, ctrl);
        build_frame(pc, rs, rt, se, ctrl);
        i_dump_req = 1'b1;
        @(negedge clk);
        i_dump_req = 1'b0;
    endtask

    // mode: 0 ready always, 1 pattern 1,0,0, 2 random. Returns at the negedge showing o_done
    // (or right after the reset check when reset_at fires).
    task automatic recv_frame(input int mode, input int mutate_at, input int reset_at);
        int k = 0, cyc = 0, hs = 0, rdy_cycles = 0;
        bit rdy, have_held = 0, mutated = 0;
        logic [7:0] held = 8'h00;
        while (k < exp_q.size() && cyc < 2000) begin
            chk("valid", o_tx_valid, 1);
            chk("busy", o_busy, 1);
            chk("done_low", o_done, 0);
            if (have_held) chk("hold_stable", o_tx_data, held);
            i_dump_req = 1'b0;
            if (k == mutate_at && !mutated) begin
                set_inputs($urandom, $urandom, $urandom, $urandom, 16'($urandom));
                i_dump_req = 1'b1;
                mutated = 1;
            end
            if (k == reset_at) begin
                i_reset = 1'b0;
                i_tx_ready = 1'b1;
                @(negedge clk);
                chk("rst_valid", o_tx_valid, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                i_reset = 1'b1;
                i_tx_ready = 1'b0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_tx_ready = rdy;
            if (rdy) begin
                chk($sformatf("byte%0d", k), o_tx_data, exp_q[k]);
                k++;
                hs++;
                rdy_cycles++;
                have_held = 0;
            end else begin
                held = o_tx_data;
                have_held = 1;
            end
            cyc++;
            @(negedge clk);
        end
        i_dump_req = 1'b0;
        i_tx_ready = 1'b0;
        chk("frame_len", hs, N);
        chk("ready_cycles", rdy_cycles, hs);
        if (mode == 0) chk("send_cycles", cyc, N);
        chk("done_pulse", o_done, 1);
        chk("done_valid", o_tx_valid, 0);
        chk("done_busy", o_busy, 1);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_valid"}, o_tx_valid, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    initial begin
        i_reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", o_tx_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_data", o_tx_data, 0);
        i_reset = 1'b1;
        @(negedge clk);

        // Basic frame
        do_req(32'h00000008, 32'h11223344, 32'hAABBCCDD, 32'hFFFFFF80, 16'h1234);
        recv_frame(0, -1, -1);
        idle_check("after_basic");

        // Backpressure
        do_req(32'h00000008, 32'h11223344, 32'hAABBCCDD, 32'hFFFFFF80, 16'h1234);
        recv_frame(1, -1, -1);
        idle_check("after_bp");

        // Snapshot isolation with an ignored mid-frame request
        do_req(32'hDEADBEEF, 32'h01020304, 32'h05060708, 32'h0000007F, 16'hBEEF);
        recv_frame(0, 5, -1);
        idle_check("after_iso1");
        idle_check("after_iso2");

        // Reset mid-frame, then a fresh frame
        do_req(32'hCAFEF00D, 32'h13572468, 32'h0F0F0F0F, 32'hFFFF8000, 16'h00FF);
        recv_frame(0, -1, 7);
        chk("post_rst_idle", o_busy, 0);
        do_req(32'h00000010, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 16'h8001);
        recv_frame(0, -1, -1);
        idle_check("after_rst_frame");

`ifdef ID_EX_DUMP_CHECKSUM_EN
        do_req('0, '0, '0, '0, '0);
        chk("csum_model", exp_q[N-1], 8'hA5);
        recv_frame(0, -1, -1);
        idle_check("after_csum");
`endif

        // Back-to-back: request in the idle cycle right after o_done
        do_req(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'h5555);
        recv_frame(0, -1, -1);
        @(negedge clk);
        chk("b2b_idle", o_busy, 0);
        do_req(32'h89ABCDEF, 32'h76543210, 32'h00FF00FF, 32'hFFFFFFFE, 16'hA5A5);
        chk("b2b_first", o_tx_data, 8'hA5);
        recv_frame(0, -1, -1);
        idle_check("after_b2b");

        // Randomized frames with random backpressure
        for (int r = 0; r < 6; r++) begin
            do_req($urandom, $urandom, $urandom, $urandom, 16'($urandom));
            recv_frame(2, (r % 2 == 0) ? int'($urandom_range(1, N - 2)) : -1, -1);
            idle_check("after_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
